mc_ctrl_fsm: RTL and testbench
==============================

# mc_ctrl_fsm

Multi-cycle MIPS control unit: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back. It drives the clock-enable and mux-select signals of the datapath's 32-bit enabled registers (PC, IR, MDR, A/B, ALUOut) and the register file. It sits directly upstream of those registers: every CE they see originates here. It waits on a memory-ready handshake, so it works with both single-cycle and wait-stated memory.

## Interface
Parameters:
- none. State, opcode and ALU encodings are fixed and come from the shared package.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]; stable while IR is not being written
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current read or write this cycle
- pc_ce  out  1  PC register CE = PCWrite | (PCWriteCond & (zero ^ is_bne))
- ir_ce  out  1  IR register CE
- mdr_ce  out  1  MDR register CE
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read, mem_write  out  1 each  memory strobes
- reg_write  out  1  register-file write enable
- reg_dst  out  2  destination register: 00 = rt, 01 = rd, 10 = $31
- mem_to_reg  out  2  write-back data: 00 = ALUOut, 01 = MDR, 10 = PC, 11 = {imm, 16'b0}
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = A
- alu_src_b  out  2  ALU B input: 00 = B, 01 = 4, 10 = ext(imm), 11 = ext(imm) << 2
- ext_zero  out  1  1 = zero-extend imm (andi/ori), 0 = sign-extend
- alu_ctrl  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 NOR, 101 SRL
- pc_source  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A (jr)
- illegal_op  out  1  one-cycle pulse when an unsupported opcode/funct is decoded
- state  out  4  current state, for debug

## Operation
- The state register is the only storage. Outputs are decoded from state, plus mem_ready in the IF/MEM states and opcode in the EXE states.
- Supported instructions: R-type add/sub/and/or/slt/nor/srl/jr, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, addi 0x08, andi 0x0C, ori 0x0D, slti 0x0A, lui 0x0F, j 0x02, jal 0x03.

States and transitions:
- IF(0): mem_read=1, iord=0. When mem_ready=1: ir_ce=1, pc_ce=1, alu_src_a=0, alu_src_b=01, ADD, pc_source=00, then go to ID. Otherwise hold in IF with no CE asserted.
- ID(1): alu_src_a=0, alu_src_b=11, ADD (branch target into ALUOut). Next state by opcode:
  - lw, sw → MA(2)
  - R-type → RX(6), except jr → JR(13)
  - beq, bne → BR(8)
  - j → J(9)
  - jal → JAL(12)
  - addi, andi, ori, slti → IX(10)
  - lui → IW(11)
  - anything else → IF, with illegal_op=1
- MA(2): alu_src_a=1, alu_src_b=10, ADD → MR(3) for lw, MW(5) for sw.
- MR(3): mem_read=1, iord=1. Hold until mem_ready=1; in that cycle mdr_ce=1 → WB(4).
- WB(4): reg_write=1, reg_dst=00, mem_to_reg=01 → IF.
- MW(5): mem_write=1, iord=1. Hold until mem_ready=1 → IF.
- RX(6): alu_src_a=1, alu_src_b=00, alu_ctrl from funct → RW(7).
- RW(7): reg_write=1, reg_dst=01, mem_to_reg=00 → IF.
- BR(8): alu_src_a=1, alu_src_b=00, SUB, PCWriteCond=1, pc_source=01 → IF.
- J(9): pc_ce=1, pc_source=10 → IF.
- IX(10): alu_src_a=1, alu_src_b=10, alu_ctrl per opcode (ADD/AND/OR/SLT), ext_zero for andi/ori → IW(11).
- IW(11): reg_write=1, reg_dst=00, mem_to_reg=11 for lui, 00 otherwise → IF.
- JAL(12): reg_write=1, reg_dst=10, mem_to_reg=10, pc_ce=1, pc_source=10 → IF.
- JR(13): pc_ce=1, pc_source=11 → IF.
- Illegal R-type funct (decoded in ID) → IF with illegal_op=1; no register or memory write occurs.
- Unused encodings 14–15 → IF on the next edge, with all strobes 0.

## Timing
- A rising edge with rst=1 loads IF. While rst=1, every enable/strobe output is forced to 0 (pc_ce, ir_ce, mdr_ce, mem_read, mem_write, reg_write, illegal_op), all selects are 0, and state=0.
- Rst asserted mid-instruction aborts it at the next edge. No partial write occurs after that edge.
- Latency with mem_ready tied to 1:
  - lw: 5 cycles
  - R-type, addi/andi/ori/slti, sw: 4 cycles
  - lui, beq/bne, j, jal, jr: 3 cycles
- Each cycle with mem_ready=0 in IF, MR or MW adds one cycle. Strobes stay asserted and stable throughout the wait.
- The PC updates exactly once in IF, plus at most once in BR/J/JAL/JR.

## Structure
- Package mc_ctrl_pkg holds the state encodings, opcode and funct constants, the alu_ctrl codes, and the select-field encodings.
- Sub-module alu_ctrl_dec (combinational: state-class, opcode, funct → alu_ctrl, ext_zero, funct_illegal).

## Test plan
- Reset: rst=1 for 2 cycles while opcode=0x23 → state=0 and all strobes 0; after release, IF asserts mem_read=1 with ir_ce=0 until mem_ready=1.
- lw 0x23 with mem_ready=1 → states 0,1,2,3,4,0; mdr_ce=1 only in state 3; reg_write=1 with mem_to_reg=01 only in state 4.
- beq, opcode 0x04: zero=1 → pc_ce=1 in BR with pc_source=01; zero=0 → pc_ce=0. Then bne 0x05 with zero=0 → pc_ce=1.
- sw 0x2B with mem_ready low for 3 cycles in MW → mem_write stays 1 for 4 cycles, reg_write never 1, return to IF.
- R-type funct 0x2A (slt) → alu_ctrl=111 in RX; reg_dst=01 in RW. funct 0x3F → illegal_op pulse in ID, next state IF, no writes.
- jal 0x03 → 3-cycle instruction: reg_dst=10, mem_to_reg=10, pc_source=10, pc_ce=1. Assert rst during MR of a lw → next state IF, no reg_write occurs.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit:
// states, opcodes, functs, ALU codes and datapath select fields.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IF  = 4'd0,
        S_ID  = 4'd1,
        S_MA  = 4'd2,
        S_MR  = 4'd3,
        S_WB  = 4'd4,
        S_MW  = 4'd5,
        S_RX  = 4'd6,
        S_RW  = 4'd7,
        S_BR  = 4'd8,
        S_J   = 4'd9,
        S_IX  = 4'd10,
        S_IW  = 4'd11,
        S_JAL = 4'd12,
        S_JR  = 4'd13
    } state_t;

    typedef enum logic [2:0] {
        AC_NONE,
        AC_ADD,
        AC_SUB,
        AC_FUNCT,
        AC_IMM
    } alu_class_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MDR = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;
    localparam logic [1:0] WB_LUI = 2'b11;

    localparam logic [1:0] SRCB_B   = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_BR  = 2'b11;

    localparam logic [1:0] PCS_ALU = 2'b00;
    localparam logic [1:0] PCS_OUT = 2'b01;
    localparam logic [1:0] PCS_JMP = 2'b10;
    localparam logic [1:0] PCS_REG = 2'b11;

    function automatic logic op_known(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
                          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI,
                          OP_LUI, OP_LW, OP_SW};
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle FSM (master)
// and the datapath it steers (slave).
interface mc_ctrl_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       pc_ce;
    logic       ir_ce;
    logic       mdr_ce;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_ce, ir_ce, mdr_ce, iord,
        output mem_read, mem_write, reg_write,
        output reg_dst, mem_to_reg,
        output alu_src_a, alu_src_b, ext_zero,
        output alu_ctrl, pc_source, illegal_op, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_ce, ir_ce, mdr_ce, iord,
        input  mem_read, mem_write, reg_write,
        input  reg_dst, mem_to_reg,
        input  alu_src_a, alu_src_b, ext_zero,
        input  alu_ctrl, pc_source, illegal_op, state
    );

endinterface

// File: rtl/alu_ctrl_dec.sv
// ALU operation decode from the FSM's ALU class,
// the opcode (immediate ops) and the R-type funct.
module alu_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  alu_class_t cls,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       ext_zero,
    output logic       funct_illegal
);

    logic [2:0] f_ctrl;

    always_comb begin
        f_ctrl        = ALU_AND;
        funct_illegal = 1'b0;
        unique case (funct)
            F_ADD:   f_ctrl = ALU_ADD;
            F_SUB:   f_ctrl = ALU_SUB;
            F_AND:   f_ctrl = ALU_AND;
            F_OR:    f_ctrl = ALU_OR;
            F_SLT:   f_ctrl = ALU_SLT;
            F_NOR:   f_ctrl = ALU_NOR;
            F_SRL:   f_ctrl = ALU_SRL;
            F_JR:    f_ctrl = ALU_ADD;
            default: funct_illegal = 1'b1;
        endcase
    end

    always_comb begin
        alu_ctrl = ALU_AND;
        ext_zero = 1'b0;
        unique case (cls)
            AC_ADD:   alu_ctrl = ALU_ADD;
            AC_SUB:   alu_ctrl = ALU_SUB;
            AC_FUNCT: alu_ctrl = f_ctrl;
            AC_IMM: begin
                unique case (opcode)
                    OP_ANDI: begin
                        alu_ctrl = ALU_AND;
                        ext_zero = 1'b1;
                    end
                    OP_ORI: begin
                        alu_ctrl = ALU_OR;
                        ext_zero = 1'b1;
                    end
                    OP_SLTI: alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EX/MEM/WB and
// drives datapath register enables and mux selects.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    mc_ctrl_if.master  bus
);

    state_t     state_q;
    state_t     state_d;
    alu_class_t cls;
    logic [2:0] dec_ctrl;
    logic       dec_ext;
    logic       funct_bad;
    logic       op_bad;

    alu_ctrl_dec u_dec (
        .cls           (cls),
        .opcode        (bus.opcode),
        .funct         (bus.funct),
        .alu_ctrl      (dec_ctrl),
        .ext_zero      (dec_ext),
        .funct_illegal (funct_bad)
    );

    assign op_bad = !op_known(bus.opcode) ||
                    (bus.opcode == OP_RTYPE && funct_bad);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_IF;
        unique case (state_q)
            S_IF: state_d = bus.mem_ready ? S_ID : S_IF;
            S_ID: begin
                if (op_bad) begin
                    state_d = S_IF;
                end else begin
                    unique case (bus.opcode)
                        OP_LW, OP_SW:   state_d = S_MA;
                        OP_RTYPE:       state_d = (bus.funct == F_JR) ? S_JR : S_RX;
                        OP_BEQ, OP_BNE: state_d = S_BR;
                        OP_J:           state_d = S_J;
                        OP_JAL:         state_d = S_JAL;
                        OP_LUI:         state_d = S_IW;
                        default:        state_d = S_IX;
                    endcase
                end
            end
            S_MA:  state_d = (bus.opcode == OP_LW) ? S_MR : S_MW;
            S_MR:  state_d = bus.mem_ready ? S_WB : S_MR;
            S_MW:  state_d = bus.mem_ready ? S_IF : S_MW;
            S_RX:  state_d = S_RW;
            S_IX:  state_d = S_IW;
            default: state_d = S_IF;
        endcase
    end

    always_comb begin
        cls = AC_NONE;
        unique case (state_q)
            S_IF:       cls = bus.mem_ready ? AC_ADD : AC_NONE;
            S_ID, S_MA: cls = AC_ADD;
            S_BR:       cls = AC_SUB;
            S_RX:       cls = AC_FUNCT;
            S_IX:       cls = AC_IMM;
            default:    cls = AC_NONE;
        endcase
    end

    // Reset overrides everything so no strobe leaks out before IF is loaded.
    always_comb begin
        bus.pc_ce      = 1'b0;
        bus.ir_ce      = 1'b0;
        bus.mdr_ce     = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = RD_RT;
        bus.mem_to_reg = WB_ALU;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRCB_B;
        bus.ext_zero   = 1'b0;
        bus.alu_ctrl   = ALU_AND;
        bus.pc_source  = PCS_ALU;
        bus.illegal_op = 1'b0;
        bus.state      = 4'd0;
        if (!rst) begin
            bus.state    = state_q;
            bus.alu_ctrl = dec_ctrl;
            bus.ext_zero = dec_ext;
            unique case (state_q)
                S_IF: begin
                    bus.mem_read = 1'b1;
                    if (bus.mem_ready) begin
                        bus.ir_ce     = 1'b1;
                        bus.pc_ce     = 1'b1;
                        bus.alu_src_b = SRCB_4;
                    end
                end
                S_ID: begin
                    bus.alu_src_b  = SRCB_BR;
                    bus.illegal_op = op_bad;
                end
                S_MA: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                end
                S_MR: begin
                    bus.mem_read = 1'b1;
                    bus.iord     = 1'b1;
                    bus.mdr_ce   = bus.mem_ready;
                end
                S_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = WB_MDR;
                end
                S_MW: begin
                    bus.mem_write = 1'b1;
                    bus.iord      = 1'b1;
                end
                S_RX: bus.alu_src_a = 1'b1;
                S_RW: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = RD_RD;
                end
                S_BR: begin
                    bus.alu_src_a = 1'b1;
                    bus.pc_source = PCS_OUT;
                    bus.pc_ce     = bus.zero ^ (bus.opcode == OP_BNE);
                end
                S_J: begin
                    bus.pc_ce     = 1'b1;
                    bus.pc_source = PCS_JMP;
                end
                S_IX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                end
                S_IW: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = (bus.opcode == OP_LUI) ? WB_LUI : WB_ALU;
                end
                S_JAL: begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = RD_RA;
                    bus.mem_to_reg = WB_PC;
                    bus.pc_ce      = 1'b1;
                    bus.pc_source  = PCS_JMP;
                end
                S_JR: begin
                    bus.pc_ce     = 1'b1;
                    bus.pc_source = PCS_REG;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench: reference model predicts each cycle's outputs
// from per-instruction state paths; a monitor compares at negedge.
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_ce;
        logic       ir_ce;
        logic       mdr_ce;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [2:0] alu_ctrl;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ob_t;

    logic clk = 1'b1;
    logic rst;

    mc_ctrl_if bus ();

    mc_ctrl_fsm u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    ob_t expq[$];
    int  path[$];
    int  cur = 0;
    int  checks = 0;
    int  passes = 0;
    int  cyc = 0;

    function automatic logic legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00)
            return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h02, 6'h08};
        return op inside {6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03,
                          6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h0F};
    endfunction

    // Whole state path an instruction walks after fetch completes.
    function automatic void plan(input logic [5:0] op, input logic [5:0] fn);
        path.delete();
        path.push_back(1);
        if (!legal(op, fn)) return;
        case (op)
            6'h23: path = '{1, 2, 3, 4};
            6'h2B: path = '{1, 2, 5};
            6'h00: path = (fn == 6'h08) ? '{1, 13} : '{1, 6, 7};
            6'h04, 6'h05: path = '{1, 8};
            6'h02: path = '{1, 9};
            6'h03: path = '{1, 12};
            6'h0F: path = '{1, 11};
            default: path = '{1, 10, 11};
        endcase
    endfunction

    function automatic logic [2:0] funct_op(input logic [5:0] fn);
        case (fn)
            6'h20: return 3'b010;
            6'h22: return 3'b110;
            6'h24: return 3'b000;
            6'h25: return 3'b001;
            6'h2A: return 3'b111;
            6'h27: return 3'b100;
            6'h02: return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic ob_t model_out(input int s, input logic r,
                                      input logic [5:0] op, input logic [5:0] fn,
                                      input logic z, input logic mr);
        ob_t o;
        o = '0;
        if (r) return o;
        o.state = 4'(s);
        case (s)
            0: begin
                o.mem_read = 1;
                if (mr) begin
                    o.ir_ce = 1; o.pc_ce = 1;
                    o.alu_src_b = 2'b01; o.alu_ctrl = 3'b010;
                end
            end
            1: begin
                o.alu_src_b = 2'b11; o.alu_ctrl = 3'b010;
                o.illegal_op = !legal(op, fn);
            end
            2: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_ctrl = 3'b010; end
            3: begin o.mem_read = 1; o.iord = 1; o.mdr_ce = mr; end
            4: begin o.reg_write = 1; o.mem_to_reg = 2'b01; end
            5: begin o.mem_write = 1; o.iord = 1; end
            6: begin o.alu_src_a = 1; o.alu_ctrl = funct_op(fn); end
            7: begin o.reg_write = 1; o.reg_dst = 2'b01; end
            8: begin
                o.alu_src_a = 1; o.alu_ctrl = 3'b110; o.pc_source = 2'b01;
                o.pc_ce = (op == 6'h04) ? z : !z;
            end
            9: begin o.pc_ce = 1; o.pc_source = 2'b10; end
            10: begin
                o.alu_src_a = 1; o.alu_src_b = 2'b10;
                case (op)
                    6'h0C: begin o.alu_ctrl = 3'b000; o.ext_zero = 1; end
                    6'h0D: begin o.alu_ctrl = 3'b001; o.ext_zero = 1; end
                    6'h0A: o.alu_ctrl = 3'b111;
                    default: o.alu_ctrl = 3'b010;
                endcase
            end
            11: begin o.reg_write = 1; o.mem_to_reg = (op == 6'h0F) ? 2'b11 : 2'b00; end
            12: begin
                o.reg_write = 1; o.reg_dst = 2'b10; o.mem_to_reg = 2'b10;
                o.pc_ce = 1; o.pc_source = 2'b10;
            end
            13: begin o.pc_ce = 1; o.pc_source = 2'b11; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic advance(input logic r, input logic [5:0] op,
                           input logic [5:0] fn, input logic mr);
        if (r) begin
            cur = 0;
            path.delete();
        end else if (cur == 0) begin
            if (mr) begin
                plan(op, fn);
                cur = path.pop_front();
            end
        end else if ((cur == 3 || cur == 5) && !mr) begin
            cur = cur;
        end else begin
            cur = (path.size() != 0) ? path.pop_front() : 0;
        end
    endtask

    task automatic step(input logic r, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic mr);
        rst           = r;
        bus.opcode    = op;
        bus.funct     = fn;
        bus.zero      = z;
        bus.mem_ready = mr;
        expq.push_back(model_out(cur, r, op, fn, z, mr));
        @(posedge clk);
        advance(r, op, fn, mr);
        #1;
    endtask

    function automatic ob_t actual();
        ob_t a;
        a.state      = bus.state;
        a.pc_ce      = bus.pc_ce;
        a.ir_ce      = bus.ir_ce;
        a.mdr_ce     = bus.mdr_ce;
        a.iord       = bus.iord;
        a.mem_read   = bus.mem_read;
        a.mem_write  = bus.mem_write;
        a.reg_write  = bus.reg_write;
        a.reg_dst    = bus.reg_dst;
        a.mem_to_reg = bus.mem_to_reg;
        a.alu_src_a  = bus.alu_src_a;
        a.alu_src_b  = bus.alu_src_b;
        a.ext_zero   = bus.ext_zero;
        a.alu_ctrl   = bus.alu_ctrl;
        a.pc_source  = bus.pc_source;
        a.illegal_op = bus.illegal_op;
        return a;
    endfunction

    initial begin : monitor
        ob_t e;
        ob_t a;
        forever begin
            @(negedge clk);
            cyc++;
            if (expq.size() != 0) begin
                e = expq.pop_front();
                a = actual();
                checks++;
                if (a === e) passes++;
                else
                    $display("FAIL outputs cycle %0d: state got %0d want %0d, vec got %h want %h",
                             cyc, a.state, e.state, a, e);
            end
        end
    end

    initial begin : driver
        logic [5:0] ops[16];
        logic [5:0] fns[10];
        logic [5:0] op;
        logic [5:0] fn;
        ops = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02,
                6'h03, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h0F, 6'h3F, 6'h01};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h02, 6'h08, 6'h3F, 6'h00};

        // reset with lw on the bus, then fetch stalls before lw runs
        step(1, 6'h23, 0, 0, 1);
        step(1, 6'h23, 0, 0, 1);
        step(0, 6'h23, 0, 0, 0);
        step(0, 6'h23, 0, 0, 0);
        repeat (5) step(0, 6'h23, 0, 0, 1);
        // beq taken, beq not taken, bne taken
        repeat (3) step(0, 6'h04, 0, 1, 1);
        repeat (3) step(0, 6'h04, 0, 0, 1);
        repeat (3) step(0, 6'h05, 0, 0, 1);
        // sw with three wait cycles in MW
        repeat (3) step(0, 6'h2B, 0, 0, 1);
        repeat (3) step(0, 6'h2B, 0, 0, 0);
        step(0, 6'h2B, 0, 0, 1);
        // slt, then illegal funct
        repeat (4) step(0, 6'h00, 6'h2A, 0, 1);
        repeat (2) step(0, 6'h00, 6'h3F, 0, 1);
        // jal, jr, lui
        repeat (3) step(0, 6'h03, 0, 0, 1);
        repeat (3) step(0, 6'h00, 6'h08, 0, 1);
        repeat (3) step(0, 6'h0F, 0, 0, 1);
        // lw aborted by reset while waiting in MR
        repeat (3) step(0, 6'h23, 0, 0, 1);
        step(0, 6'h23, 0, 0, 0);
        step(1, 6'h23, 0, 0, 1);
        repeat (2) step(0, 6'h00, 6'h20, 0, 1);

        op = 6'h00;
        fn = 6'h20;
        for (int i = 0; i < 1500; i++) begin
            if (cur == 0) begin
                op = ops[$urandom_range(0, 15)];
                fn = fns[$urandom_range(0, 9)];
            end
            step(($urandom_range(0, 59) == 0), op, fn,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end

        @(negedge clk);
        #1;
        checks++;
        if (expq.size() == 0) passes++;
        else $display("FAIL drain: got %0d pending, want 0", expq.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
